// File: rtl/apb_mst_bridge_pkg.sv
// Shared types and constants for the APB requester bridge.
package apb_mst_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  // Read data returned with an aborted (timed-out) transfer.
  localparam logic [31:0] TMOUT_RDATA = 32'hdead_1eaf;

endpackage

// File: rtl/apb_mst_bridge_if.sv
// Request/ack handshake plus APB3 bus signals of the requester bridge.
// modport master: the bridge side; modport slave: the requester/completer side.
interface apb_mst_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);

  logic                  req_vld;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr_en;
  logic                  req_rd_en;
  logic [DATA_WIDTH-1:0] req_wr_data;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] ack_rd_data;
  logic                  ack_err;
  logic                  req_drop;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  req_vld, req_addr, req_wr_en, req_rd_en, req_wr_data,
    input  prdata, pready, pslverr,
    output ack_vld, ack_rd_data, ack_err, req_drop, busy,
    output psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_vld, req_addr, req_wr_en, req_rd_en, req_wr_data,
    output prdata, pready, pslverr,
    input  ack_vld, ack_rd_data, ack_err, req_drop, busy,
    input  psel, penable, paddr, pwrite, pwdata
  );

endinterface

// File: rtl/apb_mst_bridge_tmr.sv
// ACCESS-phase watchdog for the APB requester bridge. Cleared while the
// bridge sits in SETUP, counts ACCESS cycles without pready, and flags the
// cycle in which the count has reached TMOUT_CYC-1.
module apb_mst_tmr #(
  parameter int TMOUT_CYC = 256
) (
  input  logic pclk,
  input  logic presetn,
  input  logic tmr_clr,
  input  logic tmr_cnt_en,
  output logic tmr_tmout
);

  localparam int               CNT_W    = $clog2(TMOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (tmr_clr) begin
      cnt_d = '0;
    end else if (tmr_cnt_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmr_tmout = (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_mst_bridge.sv
// APB3 requester bridge: turns single-cycle requests into SETUP/ACCESS
// transfers, one outstanding at a time, and returns a registered ack pulse.
// Optional ACCESS-phase timeout: define APB_MST_BRIDGE_TMOUT_EN.
module apb_mst_bridge
  import apb_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TMOUT_CYC  = 256
) (
  input logic              pclk,
  input logic              presetn,
  apb_mst_bridge_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] TMOUT_DATA = DATA_WIDTH'(TMOUT_RDATA);

  if (TMOUT_CYC < 2 || TMOUT_CYC > 65535) begin : g_tmout_range
    $error("apb_mst_bridge: TMOUT_CYC must be in 2..65535");
  end

  state_e                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  ack_vld_q;
  logic                  ack_err_q;
  logic [DATA_WIDTH-1:0] ack_rd_q;
  logic                  drop_q;
  logic                  tmout;

  // Direction is taken from req_wr_en alone; a request without it is a read.
  logic unused_rd_en;
  assign unused_rd_en = bus.req_rd_en;

`ifdef APB_MST_BRIDGE_TMOUT_EN
  apb_mst_tmr #(
    .TMOUT_CYC (TMOUT_CYC)
  ) u_tmr (
    .pclk       (pclk),
    .presetn    (presetn),
    .tmr_clr    (state_q == S_SETUP),
    .tmr_cnt_en ((state_q == S_ACCESS) && !bus.pready),
    .tmr_tmout  (tmout)
  );
`else
  assign tmout = 1'b0;
`endif

  // Transfer FSM with registered APB, ack and drop outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      ack_vld_q <= 1'b0;
      ack_err_q <= 1'b0;
      ack_rd_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      ack_vld_q <= 1'b0;
      drop_q    <= bus.req_vld && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.req_vld) begin
            state_q <= S_SETUP;
            psel_q  <= 1'b1;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wr_data;
            wr_q    <= bus.req_wr_en;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          // pready takes priority over a coincident timeout.
          if (bus.pready || tmout) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            ack_vld_q <= 1'b1;
            ack_err_q <= bus.pready ? bus.pslverr : 1'b1;
            ack_rd_q  <= bus.pready ? (wr_q ? '0 : bus.prdata) : TMOUT_DATA;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = addr_q;
  assign bus.pwrite      = wr_q;
  assign bus.pwdata      = wdata_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ack_vld     = ack_vld_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.ack_rd_data = ack_rd_q;
  assign bus.req_drop    = drop_q;

endmodule
